// File: rtl/y_wr_coalescer_pkg.sv
// ---------------------------------------------------------------------------
// y_wr_coalescer_pkg
//   Shared definitions for the Y write coalescer:
//   - ywc_state_t  : coalescer FSM states (EMPTY, ACCUM, ISSUE)
//   - YWC_L        : lanes per write beat for the default geometry
//   - YWC_LANE_W   : width of a lane index for the default geometry
//   - ywc_entry_t  : input FIFO entry {idx, data}
// ---------------------------------------------------------------------------
package y_wr_coalescer_pkg;

  localparam int YWC_DW        = 16;
  localparam int YWC_IDX_W     = 16;
  localparam int YWC_BUS_BYTES = 32;
  localparam int YWC_L         = YWC_BUS_BYTES * 8 / YWC_DW;
  localparam int YWC_LANE_W    = $clog2(YWC_L);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ISSUE = 2'd2
  } ywc_state_t;

  typedef struct packed {
    logic [YWC_IDX_W-1:0] idx;
    logic [YWC_DW-1:0]    data;
  } ywc_entry_t;

endpackage

// File: rtl/ywc_fifo.sv
// ---------------------------------------------------------------------------
// ywc_fifo
//   Synchronous first-word-fall-through FIFO used as the input skid buffer.
//   rdata always shows the oldest entry while empty is low.
//   Ports:
//     clk, rstn      clock, asynchronous active-low reset (clears pointers)
//     push, wdata    write strobe and data (caller guarantees space, or a
//                    simultaneous pop when full)
//     pop            read strobe (caller guarantees not empty)
//     rdata          head entry
//     full, empty    status flags
// ---------------------------------------------------------------------------
module ywc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/y_wr_coalescer.sv
// ---------------------------------------------------------------------------
// y_wr_coalescer
//   Collects scalar y results (idx, data) from the SSM block and merges
//   elements that fall into the same BUS_BYTES-aligned beat into a single
//   strobed write. Elements go through a small skid FIFO (no backpressure on
//   the result side; a full FIFO drops and sets the sticky overflow flag).
//
//   Optional feature: define YWC_TIMEOUT_EN to force-issue a partial beat
//   after TIMEOUT consecutive ACCUM cycles without a pop.
//
//   Ports:
//     clk, rstn            clock, asynchronous active-low reset
//     y_valid_i/y_data_i/y_idx_i   result strobe, element, flat index
//     base_addr_i          byte base of the Y buffer (BUS_BYTES aligned)
//     flush_i              force-issue the open beat (ACCUM only)
//     wr_valid_o/wr_ready_i        write handshake
//     wr_addr_o/wr_data_o/wr_strb_o  beat address, data, byte enables
//     overflow_o           sticky: an element was dropped
//     idle_o               FIFO empty, no open beat, nothing pending
//     dbg_state_o          current coalescer FSM state
//
//   Handshake: wr_valid_o stays high with addr/data/strb stable until
//   wr_ready_i is sampled high on a rising clk edge; the beat transfers on
//   that edge. Reset while wr_valid_o is high discards the beat.
// ---------------------------------------------------------------------------
module y_wr_coalescer
  import y_wr_coalescer_pkg::*;
#(
  parameter int DW         = YWC_DW,
  parameter int BUS_BYTES  = YWC_BUS_BYTES,
  parameter int IDX_W      = YWC_IDX_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   y_valid_i,
  input  logic [DW-1:0]          y_data_i,
  input  logic [IDX_W-1:0]       y_idx_i,
  input  logic [63:0]            base_addr_i,
  input  logic                   flush_i,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i,
  output logic [63:0]            wr_addr_o,
  output logic [BUS_BYTES*8-1:0] wr_data_o,
  output logic [BUS_BYTES-1:0]   wr_strb_o,
  output logic                   overflow_o,
  output logic                   idle_o,
  output logic [1:0]             dbg_state_o
);

  localparam int BPL    = DW / 8;              // bytes per lane
  localparam int L      = BUS_BYTES * 8 / DW;  // lanes per beat
  localparam int LANE_W = $clog2(L);
  localparam int BSH    = $clog2(BPL);
  localparam int BW     = BUS_BYTES * 8;

  // Elaboration-time sanity hook for unsupported geometries.
  if (TIMEOUT < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      YWC_L < 2 || YWC_LANE_W < 1 || L < 2) begin : g_cfg_invalid
  end

  // -------------------------------------------------------------------------
  // Address helpers
  // -------------------------------------------------------------------------
  function automatic logic [63:0] byte_addr(input logic [63:0]          base,
                                            input logic [YWC_IDX_W-1:0] idx);
    return base + (64'(idx) * 64'(BPL));
  endfunction

  function automatic logic [63:0] beat_of(input logic [63:0] ba);
    return ba & ~64'(BUS_BYTES - 1);
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [63:0] ba);
    return ba[BSH +: LANE_W];
  endfunction

  // -------------------------------------------------------------------------
  // Input FIFO
  // -------------------------------------------------------------------------
  ywc_entry_t push_e;
  ywc_entry_t f_rdata;
  logic       f_push;
  logic       f_pop;
  logic       f_full;
  logic       f_empty;

  assign push_e.idx  = y_idx_i;
  assign push_e.data = y_data_i;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign f_push = y_valid_i && (!f_full || f_pop);

  ywc_fifo #(
    .W     ($bits(ywc_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (f_push),
    .wdata (push_e),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  // -------------------------------------------------------------------------
  // Coalescer state
  // -------------------------------------------------------------------------
  ywc_state_t      state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  logic [BW-1:0]   data_q, data_d;
  logic [L-1:0]    set_q, set_d;
  ywc_entry_t      held_q, held_d;
  logic            held_v_q, held_v_d;
  logic            overflow_q;
  logic            tmo_hit;

  logic [63:0]       pop_ba, pop_beat, held_ba, held_beat;
  logic [LANE_W-1:0] pop_lane, held_lane;

  assign pop_ba    = byte_addr(base_addr_i, f_rdata.idx);
  assign pop_beat  = beat_of(pop_ba);
  assign pop_lane  = lane_of(pop_ba);
  assign held_ba   = byte_addr(base_addr_i, held_q.idx);
  assign held_beat = beat_of(held_ba);
  assign held_lane = lane_of(held_ba);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    set_d    = set_q;
    held_d   = held_q;
    held_v_d = held_v_q;
    f_pop    = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (!f_empty) begin
          f_pop                         = 1'b1;
          addr_d                        = pop_beat;
          data_d                        = '0;
          data_d[int'(pop_lane)*DW +: DW] = f_rdata.data;
          set_d                         = '0;
          set_d[pop_lane]               = 1'b1;
          state_d                       = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (&set_q) begin
          // Beat completed by the previous merge; issue without popping.
          state_d = ST_ISSUE;
        end else if (!f_empty) begin
          f_pop = 1'b1;
          if (pop_beat == addr_q && !set_q[pop_lane]) begin
            data_d[int'(pop_lane)*DW +: DW] = f_rdata.data;
            set_d[pop_lane]                 = 1'b1;
            if (flush_i) state_d = ST_ISSUE;
          end else begin
            // Other beat or duplicate lane: park it, never overwrite.
            held_d   = f_rdata;
            held_v_d = 1'b1;
            state_d  = ST_ISSUE;
          end
        end else if (flush_i || tmo_hit) begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (wr_ready_i) begin
          if (held_v_q) begin
            addr_d                           = held_beat;
            data_d                           = '0;
            data_d[int'(held_lane)*DW +: DW] = held_q.data;
            set_d                            = '0;
            set_d[held_lane]                 = 1'b1;
            held_v_d                         = 1'b0;
            state_d                          = ST_ACCUM;
          end else begin
            data_d  = '0;
            set_d   = '0;
            state_d = ST_EMPTY;
          end
        end
      end

      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_EMPTY;
      addr_q     <= '0;
      data_q     <= '0;
      set_q      <= '0;
      held_q     <= '0;
      held_v_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      set_q    <= set_d;
      held_q   <= held_d;
      held_v_q <= held_v_d;
      if (y_valid_i && !f_push) overflow_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Idle timeout
  // -------------------------------------------------------------------------
`ifdef YWC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  // Fires on the TIMEOUT-th consecutive ACCUM cycle without a pop.
  assign tmo_hit = (state_q == ST_ACCUM) && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= '0;
    end else if (state_q == ST_ACCUM && !f_pop && state_d == ST_ACCUM) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wr_valid_o  = (state_q == ST_ISSUE);
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign overflow_o  = overflow_q;
  assign idle_o      = f_empty && (state_q == ST_EMPTY) && !held_v_q;
  assign dbg_state_o = state_q;

  for (genvar g = 0; g < L; g++) begin : g_strb
    assign wr_strb_o[g*BPL +: BPL] = {BPL{set_q[g]}};
  end

endmodule

// File: tb/tb_y_wr_coalescer.sv
// ---------------------------------------------------------------------------
// tb_y_wr_coalescer
//   Self-checking bench for y_wr_coalescer with default parameters
//   (DW=16, BUS_BYTES=32 -> 16 lanes, FIFO_DEPTH=8, TIMEOUT=16).
//   Expected beats come from a grouping model: walk the element stream in
//   order, keep one open beat, close it on a different beat address, a
//   repeated lane, all lanes filled, or the final flush.
// ---------------------------------------------------------------------------
module tb_y_wr_coalescer;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         y_valid;
  logic [15:0]  y_data;
  logic [15:0]  y_idx;
  logic [63:0]  base_addr;
  logic         flush;
  logic         wr_valid;
  logic         wr_ready;
  logic [63:0]  wr_addr;
  logic [255:0] wr_data;
  logic [31:0]  wr_strb;
  logic         overflow;
  logic         idle;
  logic [1:0]   dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // stimulus log and scoreboard queues
  logic [15:0]  in_idx_q[$];
  logic [15:0]  in_data_q[$];
  logic [63:0]  exp_addr_q[$];
  logic [255:0] exp_data_q[$];
  logic [31:0]  exp_strb_q[$];
  logic [63:0]  obs_addr_q[$];
  logic [255:0] obs_data_q[$];
  logic [31:0]  obs_strb_q[$];

  y_wr_coalescer dut (
    .clk         (clk),
    .rstn        (rstn),
    .y_valid_i   (y_valid),
    .y_data_i    (y_data),
    .y_idx_i     (y_idx),
    .base_addr_i (base_addr),
    .flush_i     (flush),
    .wr_valid_o  (wr_valid),
    .wr_ready_i  (wr_ready),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_strb_o   (wr_strb),
    .overflow_o  (overflow),
    .idle_o      (idle),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Capture each beat that will transfer on the next rising edge.
  always @(negedge clk) begin
    if (rstn && wr_valid && wr_ready) begin
      obs_addr_q.push_back(wr_addr);
      obs_data_q.push_back(wr_data);
      obs_strb_q.push_back(wr_strb);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_elem(input logic [15:0] idx, input logic [15:0] data);
    y_valid = 1'b1;
    y_idx   = idx;
    y_data  = data;
    in_idx_q.push_back(idx);
    in_data_q.push_back(data);
    step();
    y_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic clear_queues();
    in_idx_q.delete();   in_data_q.delete();
    exp_addr_q.delete(); exp_data_q.delete(); exp_strb_q.delete();
    obs_addr_q.delete(); obs_data_q.delete(); obs_strb_q.delete();
  endtask

  // ---------------- reference model ----------------
  task automatic model_emit(input logic [63:0] a, input logic [255:0] d,
                            input logic [15:0] set);
    logic [31:0] s;
    for (int l = 0; l < 16; l++) begin
      s[2*l]   = set[l];
      s[2*l+1] = set[l];
    end
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
    exp_strb_q.push_back(s);
  endtask

  task automatic model_run();
    logic [63:0]  cur = '0;
    logic [255:0] d = '0;
    logic [15:0]  set = '0;
    bit           open = 1'b0;
    foreach (in_idx_q[i]) begin
      logic [63:0] ba;
      logic [63:0] beat;
      int          lane;
      ba   = base_addr + 64'(in_idx_q[i]) * 64'd2;
      beat = ba & ~64'h1f;
      lane = int'((ba / 2) % 16);
      if (open && beat == cur && !set[lane]) begin
        d[lane*16 +: 16] = in_data_q[i];
        set[lane] = 1'b1;
        if (set == 16'hffff) begin
          model_emit(cur, d, set);
          open = 1'b0;
        end
      end else begin
        if (open) model_emit(cur, d, set);
        cur = beat;
        d = '0;
        set = '0;
        d[lane*16 +: 16] = in_data_q[i];
        set[lane] = 1'b1;
        open = 1'b1;
      end
    end
    if (open) model_emit(cur, d, set);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; y_valid = 1'b0; y_data = '0; y_idx = '0;
    base_addr = '0; flush = 1'b0; wr_ready = 1'b1;
    #3;
    n_total++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset wr_valid: got %b want 0", wr_valid); end
    n_total++; if (wr_addr !== 64'd0) begin n_bad++; $display("FAIL reset wr_addr: got %h want 0", wr_addr); end
    n_total++; if (wr_data !== 256'd0) begin n_bad++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
    n_total++; if (wr_strb !== 32'd0) begin n_bad++; $display("FAIL reset wr_strb: got %h want 0", wr_strb); end
    n_total++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
    n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset idle: got %b want 1", idle); end
    repeat (3) step();
    rstn = 1'b1;
    repeat (2) step();
    n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset idle_after_release: got %b want 1", idle); end
  endtask

  task automatic test_full_beat();
    clear_queues();
    for (int i = 0; i < 16; i++) drive_elem(16'(i), 16'($urandom));
    n_total++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL full_beat early_valid_k15: got %b want 0", wr_valid); end
    step();
    n_total++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL full_beat early_valid_k16: got %b want 0", wr_valid); end
    step();
    n_total++; if (wr_valid !== 1'b1) begin n_bad++; $display("FAIL full_beat valid_k17: got %b want 1", wr_valid); end
    repeat (4) step();
    model_run();
    n_total++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin n_bad++; $display("FAIL full_beat count: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
    foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
      n_total++;
      if ({obs_addr_q[i], obs_strb_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_strb_q[i], exp_data_q[i]}) begin
        n_bad++; $display("FAIL full_beat beat%0d: got a=%h s=%h d=%h want a=%h s=%h d=%h", i, obs_addr_q[i], obs_strb_q[i], obs_data_q[i], exp_addr_q[i], exp_strb_q[i], exp_data_q[i]);
      end
    end
    n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL full_beat idle: got %b want 1", idle); end
  endtask

  task automatic test_pmajor();
    clear_queues();
    drive_elem(16'd0,   16'($urandom));
    drive_elem(16'd64,  16'($urandom));
    drive_elem(16'd128, 16'($urandom));
    repeat (6) step();
    pulse_flush();
    repeat (5) step();
    model_run();
    n_total++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin n_bad++; $display("FAIL pmajor count: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
    foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
      n_total++;
      if ({obs_addr_q[i], obs_strb_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_strb_q[i], exp_data_q[i]}) begin
        n_bad++; $display("FAIL pmajor beat%0d: got a=%h s=%h d=%h want a=%h s=%h d=%h", i, obs_addr_q[i], obs_strb_q[i], obs_data_q[i], exp_addr_q[i], exp_strb_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic test_duplicate();
    clear_queues();
    drive_elem(16'd5, 16'h1111 ^ 16'($urandom_range(0, 255)));
    drive_elem(16'd5, 16'h8888 ^ 16'($urandom_range(0, 255)));
    repeat (6) step();
    pulse_flush();
    repeat (5) step();
    model_run();
    n_total++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin n_bad++; $display("FAIL duplicate count: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
    foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
      n_total++;
      if ({obs_addr_q[i], obs_strb_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_strb_q[i], exp_data_q[i]}) begin
        n_bad++; $display("FAIL duplicate beat%0d: got a=%h s=%h d=%h want a=%h s=%h d=%h", i, obs_addr_q[i], obs_strb_q[i], obs_data_q[i], exp_addr_q[i], exp_strb_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int want_early;
    clear_queues();
    drive_elem(16'd3, 16'($urandom));
    repeat (TMO + 4) step();
`ifdef YWC_TIMEOUT_EN
    want_early = 1;
`else
    want_early = 0;
`endif
    n_total++;
    if (obs_addr_q.size() !== want_early) begin n_bad++; $display("FAIL timeout beats_before_flush: got %0d want %0d", obs_addr_q.size(), want_early); end
    if (want_early == 0) begin
      pulse_flush();
      repeat (4) step();
    end
    model_run();
    n_total++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin n_bad++; $display("FAIL timeout count: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
    foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
      n_total++;
      if ({obs_addr_q[i], obs_strb_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_strb_q[i], exp_data_q[i]}) begin
        n_bad++; $display("FAIL timeout beat%0d: got a=%h s=%h d=%h want a=%h s=%h d=%h", i, obs_addr_q[i], obs_strb_q[i], obs_data_q[i], exp_addr_q[i], exp_strb_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] idx;
    clear_queues();
    base_addr = {32'($urandom), 32'($urandom)} & ~64'h1f;
    idx = 16'($urandom_range(0, 95));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) idx = idx + 16'd1;
      else idx = 16'($urandom_range(0, 95));
      drive_elem(idx, 16'($urandom));
      repeat ($urandom_range(1, 3)) step();
    end
    repeat (10) step();
    pulse_flush();
    repeat (6) step();
    model_run();
    n_total++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin n_bad++; $display("FAIL random count: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
    foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
      n_total++;
      if ({obs_addr_q[i], obs_strb_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_strb_q[i], exp_data_q[i]}) begin
        n_bad++; $display("FAIL random beat%0d: got a=%h s=%h d=%h want a=%h s=%h d=%h", i, obs_addr_q[i], obs_strb_q[i], obs_data_q[i], exp_addr_q[i], exp_strb_q[i], exp_data_q[i]);
      end
    end
    n_total++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL random overflow: got %b want 0", overflow); end
    base_addr = '0;
  endtask

  task automatic test_stall();
    clear_queues();
    wr_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_elem(16'(i * 16), 16'($urandom));
    repeat (5) step();
    // only the first 10 elements survive: one open, one held, eight queued
    while (in_idx_q.size() > 10) begin
      void'(in_idx_q.pop_back());
      void'(in_data_q.pop_back());
    end
    model_run();
    n_total++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL stall overflow: got %b want 1", overflow); end
    n_total++; if (wr_valid !== 1'b1) begin n_bad++; $display("FAIL stall valid: got %b want 1", wr_valid); end
    n_total++;
    if ({wr_addr, wr_strb, wr_data} !== {exp_addr_q[0], exp_strb_q[0], exp_data_q[0]}) begin
      n_bad++; $display("FAIL stall hold_a: got a=%h s=%h want a=%h s=%h", wr_addr, wr_strb, exp_addr_q[0], exp_strb_q[0]);
    end
    repeat (5) step();
    n_total++;
    if ({wr_valid, wr_addr, wr_strb, wr_data} !== {1'b1, exp_addr_q[0], exp_strb_q[0], exp_data_q[0]}) begin
      n_bad++; $display("FAIL stall hold_b: got v=%b a=%h s=%h want v=1 a=%h s=%h", wr_valid, wr_addr, wr_strb, exp_addr_q[0], exp_strb_q[0]);
    end
    wr_ready = 1'b1;
    repeat (30) step();
    pulse_flush();
    repeat (5) step();
    n_total++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin n_bad++; $display("FAIL stall count: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
    foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
      n_total++;
      if ({obs_addr_q[i], obs_strb_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_strb_q[i], exp_data_q[i]}) begin
        n_bad++; $display("FAIL stall beat%0d: got a=%h s=%h d=%h want a=%h s=%h d=%h", i, obs_addr_q[i], obs_strb_q[i], obs_data_q[i], exp_addr_q[i], exp_strb_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    int waited;
    clear_queues();
    wr_ready = 1'b0;
    drive_elem(16'd0,  16'($urandom));
    drive_elem(16'd16, 16'($urandom));
    waited = 0;
    while (!wr_valid && waited < 10) begin
      step();
      waited++;
    end
    n_total++; if (wr_valid !== 1'b1) begin n_bad++; $display("FAIL reset_mid reach_issue: got %b want 1", wr_valid); end
    #2 rstn = 1'b0;
    #1;
    n_total++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid valid: got %b want 0", wr_valid); end
    n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_mid idle: got %b want 1", idle); end
    n_total++; if (wr_strb !== 32'd0) begin n_bad++; $display("FAIL reset_mid strb: got %h want 0", wr_strb); end
    n_total++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_mid overflow: got %b want 0", overflow); end
    repeat (2) step();
    rstn = 1'b1;
    wr_ready = 1'b1;
    step();
    clear_queues();
    for (int i = 0; i < 16; i++) drive_elem(16'(i), 16'($urandom));
    repeat (6) step();
    model_run();
    n_total++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin n_bad++; $display("FAIL reset_mid count: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
    foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
      n_total++;
      if ({obs_addr_q[i], obs_strb_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_strb_q[i], exp_data_q[i]}) begin
        n_bad++; $display("FAIL reset_mid beat%0d: got a=%h s=%h d=%h want a=%h s=%h d=%h", i, obs_addr_q[i], obs_strb_q[i], obs_data_q[i], exp_addr_q[i], exp_strb_q[i], exp_data_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_beat();
    test_pmajor();
    test_duplicate();
    test_timeout();
    test_random();
    test_stall();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
